fifo_check: RTL and testbench

FIFO_CHECK -- requirements
Module: fifo_check

---
 rtl/fifo_check_pkg.sv | 22 ++
 rtl/fifo_check.sv | 136 +++++++++++++
 tb/tb_fifo_check.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_check_pkg.sv
// Shared definitions for the FIFO pattern checker: state encoding,
// the "no error seen" marker and a saturating counter helper.
package fifo_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] NO_ERR = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == NO_ERR) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fifo_check.sv
// Drains size*times words from a FIFO and checks each against the running
// index pattern (n mod 2^WIDTH), reporting mismatch count and first bad index.
module fifo_check
  import fifo_check_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [31:0]      size,
  input  logic [31:0]      times,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             fifo_empty,
  input  logic             ap_start,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic             ap_done,
  output logic [31:0]      err_count,
  output logic [31:0]      first_err_idx
);

  state_t      state_r;
  state_t      state_s;
  logic [31:0] size_r;
  logic [31:0] times_r;
  logic [31:0] word_r;
  logic [31:0] pass_r;
  logic [31:0] gidx_r;
  logic        pend_r;
  logic [31:0] pend_idx_r;
  logic [31:0] err_count_r;
  logic [31:0] first_err_r;

  logic        rd_en_s;
  logic        idle_s;
  logic        ready_s;
  logic        done_s;
  logic        last_s;
  logic        mismatch_s;

  assign last_s = (word_r == size_r - 32'd1) && (pass_r == times_r - 32'd1);
  // Data for a strobe issued last cycle is on the bus now.
  assign mismatch_s = pend_r && (fifo_rd_data != pend_idx_r[WIDTH-1:0]);

  // Next-state and handshake/strobe decode
  always_comb begin
    state_s = state_r;
    rd_en_s = 1'b0;
    idle_s  = 1'b0;
    ready_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        idle_s = 1'b1;
        if (ap_start) begin
          ready_s = 1'b1;
          if ((size == 32'd0) || (times == 32'd0)) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        rd_en_s = !fifo_empty;
        if (rd_en_s && last_s) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN:   state_s = DONE;
      DONE: begin
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  assign fifo_rd_en    = rd_en_s;
  assign ap_idle       = idle_s;
  assign ap_ready      = ready_s;
  assign ap_done       = done_s;
  assign err_count     = err_count_r;
  assign first_err_idx = first_err_r;

  // State, job parameters, position counters and error bookkeeping
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r     <= IDLE;
      size_r      <= 32'd0;
      times_r     <= 32'd0;
      word_r      <= 32'd0;
      pass_r      <= 32'd0;
      gidx_r      <= 32'd0;
      pend_r      <= 1'b0;
      pend_idx_r  <= 32'd0;
      err_count_r <= 32'd0;
      first_err_r <= NO_ERR;
    end else begin
      state_r <= state_s;
      pend_r  <= rd_en_s;
      if (ready_s) begin
        size_r  <= size;
        times_r <= times;
        word_r  <= 32'd0;
        pass_r  <= 32'd0;
        gidx_r  <= 32'd0;
      end else if (rd_en_s) begin
        pend_idx_r <= gidx_r;
        gidx_r     <= gidx_r + 32'd1;
        if (word_r == size_r - 32'd1) begin
          word_r <= 32'd0;
          pass_r <= pass_r + 32'd1;
        end else begin
          word_r <= word_r + 32'd1;
        end
      end
      // A zero count means nothing recorded yet, since the count saturates.
      if (ready_s) begin
        err_count_r <= 32'd0;
        first_err_r <= NO_ERR;
      end else if (mismatch_s) begin
        err_count_r <= sat_inc(err_count_r);
        if (err_count_r == 32'd0) begin
          first_err_r <= pend_idx_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_check.sv
// Directed self-checking bench for fifo_check: pattern source behind a FIFO
// model, optional producer stalls, corruption, reset abort and back-to-back jobs.
module tb_fifo_check;
  import fifo_check_pkg::*;

  localparam int WIDTH = 8;

  logic             ap_clk = 1'b0;
  logic             ap_rst = 1'b1;
  logic             ap_start = 1'b0;
  logic [31:0]      size = 32'd0;
  logic [31:0]      times = 32'd0;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data = '0;
  logic             fifo_empty;
  logic             ap_idle;
  logic             ap_ready;
  logic             ap_done;
  logic [31:0]      err_count;
  logic [31:0]      first_err_idx;

  logic [WIDTH-1:0] mem [0:511];
  int   rd_ptr = 0;
  logic stall = 1'b0;
  logic stall_en = 1'b0;
  int   stall_left = 0;
  logic clr_stats = 1'b1;

  int cyc = 0;
  int ready_cnt = 0, done_cnt = 0, rd_cnt = 0, rd_empty_cnt = 0;
  int ready_cyc = 0, ready2_cyc = 0, done_cyc = 0, last_rd_cyc = 0;
  int n_checks = 0, n_pass = 0;

  fifo_check #(.WIDTH(WIDTH)) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .size          (size),
    .times         (times),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_empty    (fifo_empty),
    .ap_start      (ap_start),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  always #5 ap_clk = ~ap_clk;

  assign fifo_empty = stall || (rd_ptr >= 512);

  // FIFO model: read data appears the cycle after the strobe
  always @(posedge ap_clk) begin
    if (clr_stats) begin
      rd_ptr <= 0;
    end else if (fifo_rd_en && rd_ptr < 512) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Producer stall generator: bursts of 0-10 empty cycles
  always @(posedge ap_clk) begin
    if (stall_left > 0) begin
      stall      <= 1'b1;
      stall_left <= stall_left - 1;
    end else begin
      stall <= 1'b0;
      if (stall_en && ($urandom_range(0, 2) == 0)) begin
        stall_left <= $urandom_range(0, 10);
      end
    end
  end

  // Mid-cycle monitor of handshakes and read strobes
  always @(negedge ap_clk) begin
    cyc <= cyc + 1;
    if (clr_stats) begin
      ready_cnt    <= 0;
      done_cnt     <= 0;
      rd_cnt       <= 0;
      rd_empty_cnt <= 0;
    end else begin
      if (ap_ready) begin
        if (ready_cnt == 0) ready_cyc <= cyc;
        else if (ready_cnt == 1) ready2_cyc <= cyc;
        ready_cnt <= ready_cnt + 1;
      end
      if (ap_done) begin
        done_cyc <= cyc;
        done_cnt <= done_cnt + 1;
      end
      if (fifo_rd_en) begin
        rd_cnt      <= rd_cnt + 1;
        last_rd_cyc <= cyc;
        if (fifo_empty) rd_empty_cnt <= rd_empty_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] sz, input logic [31:0] tm, input logic hold);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    size      = sz;
    times     = tm;
    ap_start  = 1'b1;
    tick();
    ap_start  = hold;
  endtask

  task automatic wait_done(input int want, input int budget, input string tag);
    int n = 0;
    while (done_cnt < want && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(done_cnt >= want), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = WIDTH'(i);

    // Reset state while ap_rst is held
    tick();
    tick();
    check_eq("rst_idle", 32'(ap_idle), 32'd1);
    check_eq("rst_ready", 32'(ap_ready), 32'd0);
    check_eq("rst_done", 32'(ap_done), 32'd0);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("rst_err", err_count, 32'd0);
    check_eq("rst_first", first_err_idx, NO_ERR);
    ap_rst = 1'b0;
    tick();

    // Ideal source, 4 x 3
    start_job(32'd4, 32'd3, 1'b0);
    wait_done(1, 200, "ideal_timeout");
    tick();
    check_eq("ideal_ready_cnt", 32'(ready_cnt), 32'd1);
    check_eq("ideal_reads", 32'(rd_cnt), 32'd12);
    check_eq("ideal_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("ideal_err", err_count, 32'd0);
    check_eq("ideal_first", first_err_idx, NO_ERR);
    check_eq("ideal_done_lat", 32'(done_cyc - last_rd_cyc), 32'd2);
    check_eq("ideal_idle_after", 32'(ap_idle), 32'd1);

    // Pattern wraps 255 -> 0 at index 256
    start_job(32'd100, 32'd4, 1'b0);
    wait_done(1, 1000, "wrap_timeout");
    check_eq("wrap_reads", 32'(rd_cnt), 32'd400);
    check_eq("wrap_err", err_count, 32'd0);
    check_eq("wrap_first", first_err_idx, NO_ERR);

    // Word 5 corrupted
    mem[5] = 8'hAA;
    start_job(32'd8, 32'd1, 1'b0);
    wait_done(1, 200, "corrupt_timeout");
    check_eq("corrupt_err", err_count, 32'd1);
    check_eq("corrupt_first", first_err_idx, 32'd5);
    tick();
    tick();
    check_eq("corrupt_hold_err", err_count, 32'd1);
    mem[5] = 8'h05;

    // Empty job: straight to DONE with no reads
    start_job(32'd0, 32'd5, 1'b0);
    wait_done(1, 50, "zero_timeout");
    check_eq("zero_done_lat", 32'(done_cyc - ready_cyc), 32'd1);
    check_eq("zero_reads", 32'(rd_cnt), 32'd0);
    check_eq("zero_err", err_count, 32'd0);

    // Producer stalls
    stall_en = 1'b1;
    start_job(32'd10, 32'd3, 1'b0);
    wait_done(1, 3000, "stall_timeout");
    stall_en = 1'b0;
    check_eq("stall_rd_while_empty", 32'(rd_empty_cnt), 32'd0);
    check_eq("stall_reads", 32'(rd_cnt), 32'd30);
    check_eq("stall_err", err_count, 32'd0);
    check_eq("stall_done_lat", 32'(done_cyc - last_rd_cyc), 32'd2);
    for (int i = 0; i < 14; i++) tick();

    // Reset mid-job abandons it
    mem[2] = 8'h55;
    start_job(32'd16, 32'd2, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check_eq("midrst_pre_err", err_count, 32'd1);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    check_eq("midrst_idle", 32'(ap_idle), 32'd1);
    check_eq("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("midrst_done", 32'(ap_done), 32'd0);
    check_eq("midrst_err", err_count, 32'd0);
    check_eq("midrst_first", first_err_idx, NO_ERR);
    for (int i = 0; i < 40; i++) tick();
    check_eq("midrst_no_done", 32'(done_cnt), 32'd0);
    mem[2] = 8'h02;
    start_job(32'd16, 32'd2, 1'b0);
    wait_done(1, 300, "postrst_timeout");
    check_eq("postrst_reads", 32'(rd_cnt), 32'd32);
    check_eq("postrst_err", err_count, 32'd0);

    // Back-to-back: start held through the job
    start_job(32'd2, 32'd1, 1'b1);
    wait_done(1, 50, "b2b_timeout");
    tick();
    ap_start = 1'b0;
    check_eq("b2b_ready_cnt", 32'(ready_cnt), 32'd2);
    check_eq("b2b_ready_after_done", 32'(ready2_cyc - done_cyc), 32'd1);
    wait_done(2, 50, "b2b_second_timeout");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
